fir_cmp_sched: RTL and testbench

//  Sequencer for the 6-tap FIR approximate/accurate pair. Accepts a sample stream (valid/ready) and keeps the 6-entry delay line.

---
 rtl/fir_cmp_sched.sv | 156 +++++++++++++++
 tb/tb_fir_cmp_sched.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fir_cmp_sched.sv
// Scheduler for the approximate/accurate 6-tap FIR pair: delay line, settle/capture sequencing, error output and statistics.
// Optional build macro FIR_CMP_SCHED_WARMUP_EN: results are not counted until the delay line holds six real samples.
module fir_cmp_sched #(
    parameter int DATA_W    = 32,
    parameter int INPUT_W   = 16,
    parameter int ER_THRESH = 8,
    parameter int LAT       = 1,
    parameter int CNT_W     = 32,
    parameter int ACC_W     = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [INPUT_W-1:0] s_data,
    output logic [DATA_W-1:0] tap_1,
    output logic [DATA_W-1:0] tap_2,
    output logic [DATA_W-1:0] tap_3,
    output logic [DATA_W-1:0] tap_4,
    output logic [DATA_W-1:0] tap_5,
    output logic [DATA_W-1:0] tap_6,
    input  logic [DATA_W-1:0] appr_out,
    input  logic [DATA_W-1:0] accu_out,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_err,
    input  logic              stat_clr,
    output logic [CNT_W-1:0]  n_samples,
    output logic [CNT_W-1:0]  n_err0,
    output logic [CNT_W-1:0]  n_err1,
    output logic [ACC_W-1:0]  err_sum
);
    localparam int SC_W = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {IDLE, SETTLE, OUT} state_t;

    state_t              state_reg, state_next;
    logic [SC_W-1:0]     settle_cnt_reg;
    logic [DATA_W-1:0]   tap_reg [1:6];
    logic                m_valid_reg;
    logic [DATA_W-1:0]   m_err_reg;
    logic [CNT_W-1:0]    n_samples_reg, n_err0_reg, n_err1_reg;
    logic [ACC_W-1:0]    err_sum_reg;

    logic                accept, capture, release_out, count_en, warm_ok;
    logic [DATA_W-1:0]   err_w;
    logic                slice_diff;

    assign accept      = s_valid && s_ready;
    assign capture     = (state_reg == SETTLE) && (settle_cnt_reg == '0);
    assign release_out = (state_reg == OUT) && m_ready;
    assign err_w       = appr_out - accu_out;
    assign slice_diff  = appr_out[DATA_W-1:ER_THRESH] != accu_out[DATA_W-1:ER_THRESH];
    assign count_en    = capture && warm_ok;

`ifdef FIR_CMP_SCHED_WARMUP_EN
    logic [2:0] fill_reg;

    always_ff @(posedge clk) begin
        if (rst)
            fill_reg <= 3'd0;
        else if (accept && fill_reg != 3'd6)
            fill_reg <= fill_reg + 3'd1;
    end

    // A capture counts once all six taps hold samples accepted since reset.
    assign warm_ok = (fill_reg == 3'd6);
`else
    assign warm_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept)      state_next = SETTLE;
            SETTLE:  if (capture)     state_next = OUT;
            OUT:     if (release_out) state_next = IDLE;
            default:                  state_next = IDLE;
        endcase
    end

    always_comb begin
        s_ready = (state_reg == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst)
            settle_cnt_reg <= '0;
        else if (accept)
            settle_cnt_reg <= SC_W'(LAT - 1);
        else if (state_reg == SETTLE && settle_cnt_reg != '0)
            settle_cnt_reg <= settle_cnt_reg - 1'b1;
    end

    // Taps only move on an accept, so both datapaths see stable inputs until the result is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i <= 6; i++)
                tap_reg[i] <= '0;
        end else if (accept) begin
            tap_reg[1] <= {{(DATA_W-INPUT_W){1'b0}}, s_data};
            for (int i = 2; i <= 6; i++)
                tap_reg[i] <= tap_reg[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_reg <= 1'b0;
            m_err_reg   <= '0;
        end else if (capture) begin
            m_valid_reg <= 1'b1;
            m_err_reg   <= err_w;
        end else if (release_out) begin
            m_valid_reg <= 1'b0;
        end
    end

    // A clear coincident with a capture wins: that capture is dropped from the statistics.
    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            n_samples_reg <= '0;
            n_err0_reg    <= '0;
            n_err1_reg    <= '0;
            err_sum_reg   <= '0;
        end else if (count_en) begin
            if (n_samples_reg != '1)
                n_samples_reg <= n_samples_reg + 1'b1;
            if (err_w != '0 && n_err0_reg != '1)
                n_err0_reg <= n_err0_reg + 1'b1;
            if (slice_diff && n_err1_reg != '1)
                n_err1_reg <= n_err1_reg + 1'b1;
            err_sum_reg <= err_sum_reg + {{(ACC_W-DATA_W){err_w[DATA_W-1]}}, err_w};
        end
    end

    assign tap_1     = tap_reg[1];
    assign tap_2     = tap_reg[2];
    assign tap_3     = tap_reg[3];
    assign tap_4     = tap_reg[4];
    assign tap_5     = tap_reg[5];
    assign tap_6     = tap_reg[6];
    assign m_valid   = m_valid_reg;
    assign m_err     = m_err_reg;
    assign n_samples = n_samples_reg;
    assign n_err0    = n_err0_reg;
    assign n_err1    = n_err1_reg;
    assign err_sum   = err_sum_reg;
endmodule

// File: tb/tb_fir_cmp_sched.sv
// Scoreboard bench for fir_cmp_sched: expected errors queued at accept, compared when the result is handed over.
module tb_fir_cmp_sched;
    logic        clk = 1'b0;
    logic        rst, s_valid, m_ready, stat_clr;
    logic [15:0] s_data;
    logic [31:0] appr, accu;
    logic        s_ready, m_valid;
    logic [31:0] tap_1, tap_2, tap_3, tap_4, tap_5, tap_6, m_err;
    logic [31:0] n_samples, n_err0, n_err1;
    logic [63:0] err_sum;

    logic        s_valid_3;
    logic        s_ready_3, m_valid_3;
    logic [31:0] t1_3, t2_3, t3_3, t4_3, t5_3, t6_3, m_err_3;
    logic [31:0] ns_3, ne0_3, ne1_3;
    logic [63:0] es_3;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mt [1:6];
    logic [31:0] e_ns, e_e0, e_e1;
    logic [63:0] e_sum;
    int          fill;

    always #5 clk = ~clk;

    fir_cmp_sched #(.LAT(1)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .tap_1(tap_1), .tap_2(tap_2), .tap_3(tap_3), .tap_4(tap_4), .tap_5(tap_5), .tap_6(tap_6),
        .appr_out(appr), .accu_out(accu), .m_valid(m_valid), .m_ready(m_ready), .m_err(m_err),
        .stat_clr(stat_clr), .n_samples(n_samples), .n_err0(n_err0), .n_err1(n_err1), .err_sum(err_sum)
    );

    fir_cmp_sched #(.LAT(3)) dut3 (
        .clk(clk), .rst(rst), .s_valid(s_valid_3), .s_ready(s_ready_3), .s_data(s_data),
        .tap_1(t1_3), .tap_2(t2_3), .tap_3(t3_3), .tap_4(t4_3), .tap_5(t5_3), .tap_6(t6_3),
        .appr_out(appr), .accu_out(accu), .m_valid(m_valid_3), .m_ready(1'b1), .m_err(m_err_3),
        .stat_clr(1'b0), .n_samples(ns_3), .n_err0(ne0_3), .n_err1(ne1_3), .err_sum(es_3)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 1; i <= 6; i++) mt[i] = '0;
        e_ns = '0; e_e0 = '0; e_e1 = '0; e_sum = '0; fill = 0;
        exp_q.delete();
    endtask

    task automatic check_taps(input string tag);
        chk({tag, "_tap1"}, tap_1, mt[1]);
        chk({tag, "_tap6"}, tap_6, mt[6]);
    endtask

    task automatic txn(input logic [15:0] smp, input logic [31:0] ap, input logic [31:0] ac,
                       input bit clr, input int hold);
        int          n;
        bit          counted;
        logic [31:0] d, exp_err;
        appr = ap; accu = ac; s_data = smp; s_valid = 1'b1;
        n = 0;
        while (!s_ready && n < 50) begin step(); n++; end
        if (!s_ready) begin
            chk("accept_timeout", 0, 1);
            s_valid = 1'b0;
            return;
        end
        step();
        s_valid = 1'b0;
        for (int i = 6; i >= 2; i--) mt[i] = mt[i-1];
        mt[1] = {16'h0, smp};
        if (fill < 6) fill++;
        d = ap - ac;
        exp_q.push_back(d);
`ifdef FIR_CMP_SCHED_WARMUP_EN
        counted = !clr && (fill == 6);
`else
        counted = !clr;
`endif
        if (clr) begin
            e_ns = '0; e_e0 = '0; e_e1 = '0; e_sum = '0;
        end else if (counted) begin
            e_ns++;
            if (d != 0) e_e0++;
            if (ap[31:8] != ac[31:8]) e_e1++;
            e_sum = e_sum + {{32{d[31]}}, d};
        end
        stat_clr = clr;
        n = 0;
        while (!m_valid && n < 20) begin step(); stat_clr = 1'b0; n++; end
        stat_clr = 1'b0;
        chk("latency", n, 1);
        if (!m_valid) return;
        exp_err = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        chk("m_err", m_err, exp_err);
        chk("n_samples", n_samples, e_ns);
        chk("n_err0", n_err0, e_e0);
        chk("n_err1", n_err1, e_e1);
        chk("err_sum", err_sum, e_sum);
        check_taps("cap");
        if (hold > 0) begin
            m_ready = 1'b0;
            s_valid = 1'b1;
            s_data  = smp + 16'd100;
            for (int c = 0; c < hold; c++) begin
                step();
                chk("bp_m_valid", m_valid, 1);
                chk("bp_m_err", m_err, exp_err);
                chk("bp_s_ready", s_ready, 0);
            end
            check_taps("bp");
            s_valid = 1'b0;
            m_ready = 1'b1;
        end
        m_ready = 1'b1;
        step();
        chk("release", m_valid, 0);
        $display("txn sample=%0d appr=0x%08h accu=0x%08h m_err=0x%08h n_samples=%0d err_sum=%0d",
                 smp, ap, ac, m_err, n_samples, $signed(err_sum));
    endtask

    initial begin
        int n;
        rst = 1'b1; s_valid = 1'b0; s_valid_3 = 1'b0; m_ready = 1'b1; stat_clr = 1'b0;
        s_data = '0; appr = '0; accu = '0;
        clear_model();
        repeat (3) step();
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_err", m_err, 0);
        chk("rst_n_samples", n_samples, 0);
        chk("rst_err_sum", err_sum, 0);
        chk("rst_tap1", tap_1, 0);
        rst = 1'b0;
        step();
        chk("rst_s_ready", s_ready, 1);

        txn(16'd1, 32'd100, 32'd100, 0, 0);
        txn(16'd2, 32'h105, 32'h100, 0, 0);
        txn(16'd3, 32'h0F0, 32'h100, 0, 0);
        for (int k = 4; k <= 7; k++) txn(16'(k), $urandom, $urandom, 0, 0);
        chk("fill_tap1", tap_1, 7);
        chk("fill_tap2", tap_2, 6);
        chk("fill_tap6", tap_6, 2);
`ifdef FIR_CMP_SCHED_WARMUP_EN
        chk("fill_n_samples", n_samples, 2);
`else
        chk("fill_n_samples", n_samples, 7);
`endif

        txn(16'd8, 32'h1234_5678, 32'h1234_0000, 0, 10);
        txn(16'd9, 32'h0000_0200, 32'h0000_0100, 1, 0);
        chk("clr_n_samples", n_samples, 0);
        for (int k = 10; k < 16; k++) txn(16'(k), $urandom_range(0, 2000), $urandom_range(0, 2000), 0, 0);

        // Reset lands on what would have been the capture edge.
        appr = 32'd5; accu = 32'd1; s_data = 16'd77; s_valid = 1'b1;
        n = 0;
        while (!s_ready && n < 50) begin step(); n++; end
        step();
        s_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        clear_model();
        chk("rstmid_m_valid", m_valid, 0);
        chk("rstmid_tap1", tap_1, 0);
        chk("rstmid_n_samples", n_samples, 0);
        step();
        chk("rstmid_m_valid2", m_valid, 0);
        chk("rstmid_s_ready", s_ready, 1);
        txn(16'd42, 32'd10, 32'd30, 0, 0);

        appr = 32'd1000; accu = 32'd999; s_data = 16'd5;
        s_valid_3 = 1'b1;
        n = 0;
        while (!s_ready_3 && n < 50) begin step(); n++; end
        step();
        s_valid_3 = 1'b0;
        n = 0;
        while (!m_valid_3 && n < 20) begin step(); n++; end
        chk("lat3_latency", n, 3);
        chk("lat3_m_err", m_err_3, 1);
        $display("txn lat3 latency=%0d m_err=0x%08h", n, m_err_3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
